// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, arbitration modes and
// small index helpers used by the arbiter and its grant picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned RR_FIXED = 0;
  localparam int unsigned RR_ROUND = 1;

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + off) mod n, valid for base < n and off <= n.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant picker: fixed priority (highest index wins) or
// round-robin starting just above the last granted index.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RR_MODE   = RR_FIXED,
  parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    if (RR_MODE == RR_ROUND) begin
      // Scan farthest-to-nearest so the nearest requester after last_i wins.
      for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
        if (req_i[wrap_add(int'(last_i), k, NUM_PORTS)]) begin
          idx_o = IDX_W'(wrap_add(int'(last_i), k, NUM_PORTS));
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (req_i[k]) begin
          idx_o = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: grants one port at a time and moves its word over
// a narrower memory bus in BEATS beats, skipping unselected write beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned RR_MODE   = RR_FIXED
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]         addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]         wdata_i,
  input  logic [NUM_PORTS*(DATA_W/BUS_W)-1:0] sel_i,
  output logic [NUM_PORTS-1:0]                ready_o,
  output logic [DATA_W-1:0]                   rdata_o,
  output logic [NUM_PORTS-1:0]                stall_o,
  output logic                                mem_ce_o,
  output logic                                mem_we_o,
  output logic [ADDR_W-1:0]                   mem_addr_o,
  output logic [BUS_W-1:0]                    mem_wdata_o,
  input  logic [BUS_W-1:0]                    mem_rdata_i,
  input  logic                                mem_hit_i
);

  localparam int unsigned BEATS = DATA_W / BUS_W;
  localparam int unsigned CNT_W = idx_width(BEATS);
  localparam int unsigned IDX_W = idx_width(NUM_PORTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BEATS-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              beat_skip;
  logic              beat_done;

  arb_pick #(
    .NUM_PORTS(NUM_PORTS),
    .RR_MODE  (RR_MODE),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    beat_skip   = 1'b0;
    beat_done   = 1'b0;
    ready_o     = '0;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          we_d    = we_i[pick_idx];
          addr_d  = addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
          sel_d   = sel_i[int'(pick_idx)*BEATS +: BEATS];
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Unselected write beats advance without touching memory.
        beat_skip   = we_q && !sel_q[cnt_q];
        beat_done   = beat_skip || mem_hit_i;
        mem_ce_o    = !beat_skip;
        mem_we_o    = we_q && !beat_skip;
        mem_addr_o  = addr_q + ADDR_W'(cnt_q);
        mem_wdata_o = wdata_q[int'(cnt_q)*BUS_W +: BUS_W];
        if (!we_q && mem_hit_i) begin
          rdata_d[int'(cnt_q)*BUS_W +: BUS_W] = mem_rdata_i;
        end
        if (beat_done) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        ready_o[grant_q] = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    stall_o = rst ? '0 : (req_i & ~ready_o);
  end

  assign rdata_o = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 2-port fixed-priority instance with a
// byte memory model and a 3-port round-robin instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t mon_a_e;
  exp_t mon_b_e;

  // ---------------- instance A: 2 ports, fixed priority ----------------
  logic [1:0]  req_a, we_a, ready_a, stall_a;
  logic [63:0] addr_a, wdata_a;
  logic [7:0]  sel_a;
  logic [31:0] rdata_a, maddr_a;
  logic        ce_a, wo_a, hit_a;
  logic [7:0]  mwdata_a, mrdata_a;
  logic [7:0]  mem_a [0:1023];

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .BUS_W(8), .RR_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .sel_i(sel_a), .ready_o(ready_a), .rdata_o(rdata_a),
    .stall_o(stall_a), .mem_ce_o(ce_a), .mem_we_o(wo_a), .mem_addr_o(maddr_a),
    .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a), .mem_hit_i(hit_a)
  );

  // Optional wait injection at byte 0x102: hit held low for 3 cycles.
  logic hold_arm;
  int   hold_cnt = 0;
  int   hold_base;
  logic hold_now;
  assign hold_now = hold_arm && ce_a && (maddr_a[9:0] == 10'h102) && ((hold_cnt - hold_base) < 3);
  assign hit_a    = !hold_now;
  assign mrdata_a = mem_a[maddr_a[9:0]];

  always @(posedge clk) begin
    if (ce_a && wo_a && hit_a) mem_a[maddr_a[9:0]] <= mwdata_a;
    if (hold_now) hold_cnt <= hold_cnt + 1;
  end

  logic [39:0] wr_log[$];
  int          at102_cnt = 0;

  always @(negedge clk) begin
    if (!ce_a) check("we_without_ce", {63'd0, wo_a}, 64'd0);
    if (ce_a && wo_a) wr_log.push_back({maddr_a, mwdata_a});
    if (ce_a && maddr_a[9:0] == 10'h102) at102_cnt++;
    if (ready_a != 2'b00) begin
      if (sb_a.size() == 0) begin
        check("sb_a_unexpected_ready", {62'd0, ready_a}, 64'd0);
      end else begin
        mon_a_e = sb_a.pop_front();
        check("sb_a_port", {62'd0, ready_a}, 64'd1 << mon_a_e.port);
        if (mon_a_e.is_rd) check("sb_a_rdata", {32'd0, rdata_a}, {32'd0, mon_a_e.rdata});
      end
    end
  end

  // ---------------- instance B: 3 ports, round-robin ----------------
  logic [2:0]  req_b, we_b, ready_b, stall_b;
  logic [95:0] addr_b, wdata_b;
  logic [11:0] sel_b;
  logic [31:0] rdata_b, maddr_b;
  logic        ce_b, wo_b, hit_b;
  logic [7:0]  mwdata_b, mrdata_b;

  assign we_b     = 3'b000;
  assign addr_b   = {32'h40, 32'h30, 32'h20};
  assign wdata_b  = '0;
  assign sel_b    = '1;
  assign hit_b    = 1'b1;
  assign mrdata_b = maddr_b[7:0];

  mem_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .BUS_W(8), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .sel_i(sel_b), .ready_o(ready_b), .rdata_o(rdata_b),
    .stall_o(stall_b), .mem_ce_o(ce_b), .mem_we_o(wo_b), .mem_addr_o(maddr_b),
    .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata_b), .mem_hit_i(hit_b)
  );

  function automatic logic [31:0] rr_exp(input int p);
    logic [7:0] a;
    a = 8'(32 + 16 * p);
    return {a + 8'd3, a + 8'd2, a + 8'd1, a};
  endfunction

  always @(negedge clk) begin
    if (ready_b != 3'b000) begin
      if (sb_b.size() == 0) begin
        check("sb_b_unexpected_ready", {61'd0, ready_b}, 64'd0);
      end else begin
        mon_b_e = sb_b.pop_front();
        check("rr_grant", {61'd0, ready_b}, 64'd1 << mon_b_e.port);
        check("rr_rdata", {32'd0, rdata_b}, {32'd0, mon_b_e.rdata});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_a(input int p, input logic rd, input logic [31:0] d);
    exp_t e;
    e.port = p; e.is_rd = rd; e.rdata = d;
    sb_a.push_back(e);
  endtask

  task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
    @(posedge clk); #1;
    we_a[p] = w;
    addr_a[p*32 +: 32] = a;
    wdata_a[p*32 +: 32] = d;
    sel_a[p*4 +: 4] = s;
    req_a[p] = 1'b1;
    lat = 0;
    @(negedge clk);
    lat++;
    check("stall_while_waiting", {63'd0, stall_a[p]}, 64'd1);
    while (!ready_a[p] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ready_a[p]) check("ready_timeout", 64'd0, 64'd1);
    else check("stall_at_ready", {63'd0, stall_a[p]}, 64'd0);
    @(posedge clk); #1;
    req_a[p] = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {62'd0, ready_a}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lat, base, hbase, got, cyc;
  logic done0, done1, stall_ok, seen;

  initial begin
    rst = 1'b1;
    req_a = 2'b11; we_a = '0; addr_a = '0; wdata_a = '0; sel_a = '0;
    req_b = 3'b111;
    hold_arm = 1'b0; hold_base = 0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
    mem_a[10'h100] = 8'h11; mem_a[10'h101] = 8'h22; mem_a[10'h102] = 8'h33; mem_a[10'h103] = 8'h44;
    mem_a[10'h104] = 8'h55; mem_a[10'h105] = 8'h66; mem_a[10'h106] = 8'h77; mem_a[10'h107] = 8'h88;

    // Reset state, with requests held so stall gating is visible.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {62'd0, ready_a}, 64'd0);
    check("rst_stall", {62'd0, stall_a}, 64'd0);
    check("rst_ce", {63'd0, ce_a}, 64'd0);
    check("rst_we", {63'd0, wo_a}, 64'd0);
    check("rst_addr", {32'd0, maddr_a}, 64'd0);
    check("rst_wdata", {56'd0, mwdata_a}, 64'd0);
    check("rst_rdata", {32'd0, rdata_a}, 64'd0);
    check("rst_rr_stall", {61'd0, stall_b}, 64'd0);
    req_a = 2'b00;
    req_b = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin: first grant after reset is port 0, then rotating.
    sb_b.push_back('{0, 1'b1, rr_exp(0)});
    sb_b.push_back('{1, 1'b1, rr_exp(1)});
    sb_b.push_back('{2, 1'b1, rr_exp(2)});
    sb_b.push_back('{0, 1'b1, rr_exp(0)});
    @(posedge clk); #1;
    req_b = 3'b111;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ready_b != 3'b000) got++;
    end
    @(posedge clk); #1;
    req_b = 3'b000;
    repeat (10) @(negedge clk);
    check("rr_grants_done", 64'(got), 64'd4);
    check("rr_sb_drained", 64'(sb_b.size()), 64'd0);

    // Zero-wait read of port 0.
    push_a(0, 1'b1, 32'h44332211);
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, lat);
    check("read_latency", 64'(lat), 64'd6);

    // Partial write of port 1: only beats 0 and 2 reach memory.
    base = wr_log.size();
    push_a(1, 1'b0, 32'h0);
    do_req(1, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, lat);
    check("wr_latency", 64'(lat), 64'd6);
    check("wr_beat_count", 64'(wr_log.size() - base), 64'd2);
    if (wr_log.size() - base == 2) begin
      check("wr_beat0", {24'd0, wr_log[base]}, {24'd0, 32'h200, 8'hDD});
      check("wr_beat2", {24'd0, wr_log[base+1]}, {24'd0, 32'h202, 8'hBB});
    end
    check("wr_untouched_201", {56'd0, mem_a[10'h201]}, 64'd0);

    // Write with no beats selected completes without memory access.
    base = wr_log.size();
    push_a(1, 1'b0, 32'h0);
    do_req(1, 1'b1, 32'h300, 32'h12345678, 4'b0000, lat);
    check("wr_nosel_latency", 64'(lat), 64'd6);
    check("wr_nosel_beats", 64'(wr_log.size() - base), 64'd0);

    // Fixed priority: both request, port 1 first, port 0 stalls throughout.
    push_a(1, 1'b1, 32'h88776655);
    push_a(0, 1'b1, 32'h44332211);
    @(posedge clk); #1;
    we_a = 2'b00;
    addr_a = {32'h104, 32'h100};
    sel_a = 8'hFF;
    req_a = 2'b11;
    done0 = 1'b0; done1 = 1'b0; stall_ok = 1'b1; cyc = 0;
    while (!done0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!ready_a[0] && !stall_a[0]) stall_ok = 1'b0;
      if (ready_a[1]) begin
        done1 = 1'b1;
        @(posedge clk); #1;
        req_a[1] = 1'b0;
      end else if (ready_a[0]) begin
        done0 = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_a = 2'b00;
    check("fixed_stall0_held", {63'd0, stall_ok}, 64'd1);
    check("fixed_both_served", {62'd0, done1, done0}, 64'd3);

    // Memory wait: hit low for 3 cycles on beat 2.
    hbase = at102_cnt;
    hold_base = hold_cnt;
    hold_arm = 1'b1;
    push_a(0, 1'b1, 32'h44332211);
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, lat);
    hold_arm = 1'b0;
    check("wait_latency", 64'(lat), 64'd9);
    check("wait_addr_held", 64'(at102_cnt - hbase), 64'd4);

    // Reset on beat 1 aborts; request re-arbitrates afterwards.
    push_a(0, 1'b1, 32'h44332211);
    @(posedge clk); #1;
    we_a[0] = 1'b0; addr_a[31:0] = 32'h100; req_a[0] = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ce_a && maddr_a == 32'h101) seen = 1'b1;
    end
    check("rst_beat1_reached", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ce", {63'd0, ce_a}, 64'd0);
    check("abort_ready", {62'd0, ready_a}, 64'd0);
    check("abort_stall", {62'd0, stall_a}, 64'd0);
    check("abort_addr", {32'd0, maddr_a}, 64'd0);
    check("abort_rdata", {32'd0, rdata_a}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    while (!ready_a[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rearb_latency", 64'(lat), 64'd6);
    @(posedge clk); #1;
    req_a = 2'b00;

    repeat (5) @(posedge clk);
    check("sb_a_drained", 64'(sb_a.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
